// File: rtl/pim_bank_ctrl.sv
// pim_bank_ctrl: single-outstanding request sequencer for four PIM banks sharing a dmux/mux data path.
module pim_bank_ctrl #(
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_bank,
  input  logic             i_req_we,
  input  logic [WIDTH-1:0] i_req_wdata,
  output logic [1:0]       o_sel,
  output logic [WIDTH-1:0] o_wdata,
  output logic [3:0]       o_bank_start,
  output logic             o_bank_we,
  input  logic [3:0]       i_bank_done,
  input  logic [WIDTH-1:0] i_bank_rdata,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_rdata,
  output logic             o_rsp_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic       r_we;
  logic       w_done;
  logic       w_to;
  // Ready is low throughout reset so no request appears accepted while the FSM is held.
  assign o_req_ready = (r_state == S_IDLE) && !i_rst;
  assign w_done      = i_bank_done[o_sel];
  assign w_to        = r_cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      o_sel        <= '0;
      o_wdata      <= '0;
      o_bank_start <= '0;
      o_bank_we    <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_rdata  <= '0;
      o_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          o_sel        <= i_req_bank;
          o_wdata      <= i_req_wdata;
          r_we         <= i_req_we;
          o_bank_start <= 4'b0001 << i_req_bank;
          o_bank_we    <= i_req_we;
          r_state      <= S_START;
        end
        S_START: begin
          o_bank_start <= '0;
          o_bank_we    <= 1'b0;
          r_cnt        <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: if (w_done || w_to) begin
          o_rsp_rdata <= (w_done && !r_we) ? i_bank_rdata : '0;
          o_rsp_err   <= !w_done;
          o_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        default: if (i_rsp_ready) begin
          o_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pim_bank_ctrl.sv
// tb_pim_bank_ctrl: directed checks of pim_bank_ctrl with TIMEOUT=8 (u0) and TIMEOUT=4 (u1).
module tb_pim_bank_ctrl;
  localparam int W = 256;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid0 = 1'b0, valid1 = 1'b0;
  logic [1:0]   bank = '0;
  logic         we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [3:0]   done = '0;
  logic [W-1:0] rdata = '0;
  logic         rsp_ready0 = 1'b0;
  logic         rsp_ready1 = 1'b1;
  logic         ready0, ready1, bwe0, bwe1, rv0, rv1, err0, err1;
  logic [1:0]   sel0, sel1;
  logic [3:0]   start0, start1;
  logic [W-1:0] owd0, owd1, ord0, ord1;
  int           n_chk = 0, n_err = 0;
  localparam logic [W-1:0] A5 = {32{8'hA5}};
  localparam logic [W-1:0] P1 = {16{16'hBEEF}};
  localparam logic [W-1:0] P2 = {8{32'h0BAD_F00D}};
  localparam logic [W-1:0] P3 = {4{64'h0123_4567_89AB_CDEF}};

  always #5 clk = ~clk;

  pim_bank_ctrl #(.WIDTH(W), .TIMEOUT(8)) u0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid0), .o_req_ready(ready0),
    .i_req_bank(bank), .i_req_we(we), .i_req_wdata(wdata), .o_sel(sel0),
    .o_wdata(owd0), .o_bank_start(start0), .o_bank_we(bwe0), .i_bank_done(done),
    .i_bank_rdata(rdata), .o_rsp_valid(rv0), .i_rsp_ready(rsp_ready0),
    .o_rsp_rdata(ord0), .o_rsp_err(err0));

  pim_bank_ctrl #(.WIDTH(W), .TIMEOUT(4)) u1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid1), .o_req_ready(ready1),
    .i_req_bank(bank), .i_req_we(we), .i_req_wdata(wdata), .o_sel(sel1),
    .o_wdata(owd1), .o_bank_start(start1), .o_bank_we(bwe1), .i_bank_done(done),
    .i_bank_rdata(rdata), .o_rsp_valid(rv1), .i_rsp_ready(rsp_ready1),
    .o_rsp_rdata(ord1), .o_rsp_err(err1));

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] b, input logic w, input logic [W-1:0] d);
    bank = b; we = w; wdata = d; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready0 = 1'b1;
    step();
    rsp_ready0 = 1'b0;
    chk("hs_valid", W'(rv0), W'(1'b0));
    chk("hs_ready", W'(ready0), W'(1'b1));
  endtask

  initial begin
    #3;
    chk("rst_ready", W'(ready0), W'(1'b0));
    chk("rst_valid", W'(rv0), W'(1'b0));
    chk("rst_start", W'(start0), W'(4'b0));
    chk("rst_sel", W'(sel0), W'(2'd0));
    chk("rst_wdata", owd0, '0);
    chk("rst_err", W'(err0), W'(1'b0));
    #9 rst = 1'b0;
    #1 chk("post_rst_ready", W'(ready0), W'(1'b1));
    // read bank 2: done arrives during START (ignored) and is sampled in WAIT
    go(2'd2, 1'b0, P1);
    chk("rd_start", W'(start0), W'(4'b0100));
    chk("rd_sel", W'(sel0), W'(2'd2));
    chk("rd_ready_busy", W'(ready0), W'(1'b0));
    done = 4'b0100; rdata = A5;
    step();
    chk("rd_start_1cyc", W'(start0), W'(4'b0));
    chk("rd_not_yet", W'(rv0), W'(1'b0));
    step();
    chk("rd_valid_t3", W'(rv0), W'(1'b1));
    chk("rd_rdata", ord0, A5);
    chk("rd_err", W'(err0), W'(1'b0));
    done = 4'b0;
    handshake();
    // write bank 1
    go(2'd1, 1'b1, W'(16'h1234));
    chk("wr_start", W'(start0), W'(4'b0010));
    chk("wr_we", W'(bwe0), W'(1'b1));
    chk("wr_wdata", owd0, W'(16'h1234));
    done = 4'b0010;
    step();
    step();
    chk("wr_valid", W'(rv0), W'(1'b1));
    chk("wr_rdata_zero", ord0, '0);
    chk("wr_err", W'(err0), W'(1'b0));
    chk("wr_wdata_hold", owd0, W'(16'h1234));
    done = 4'b0;
    handshake();
    // bank 3 timeout while other banks' done bits toggle
    go(2'd3, 1'b0, P2);
    for (int i = 0; i < 8; i++) begin
      done = i[0] ? 4'b0111 : 4'b0101;
      step();
    end
    chk("to_not_early", W'(rv0), W'(1'b0));
    step();
    chk("to_valid", W'(rv0), W'(1'b1));
    chk("to_err", W'(err0), W'(1'b1));
    chk("to_rdata_zero", ord0, '0);
    done = 4'b0;
    // held response with a pending request
    bank = 2'd1; we = 1'b0; wdata = P3; valid0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", W'(rv0), W'(1'b1));
      chk("hold_err", W'(err0), W'(1'b1));
      chk("hold_ready", W'(ready0), W'(1'b0));
      chk("hold_sel", W'(sel0), W'(2'd3));
    end
    rsp_ready0 = 1'b1;
    step();
    rsp_ready0 = 1'b0;
    chk("b2b_no_accept", W'(start0), W'(4'b0));
    chk("b2b_ready", W'(ready0), W'(1'b1));
    step();
    valid0 = 1'b0;
    chk("b2b_accept", W'(start0), W'(4'b0010));
    chk("b2b_wdata", owd0, P3);
    done = 4'b0010; rdata = P1;
    step();
    step();
    chk("b2b_rdata", ord0, P1);
    done = 4'b0;
    handshake();
    // reset during WAIT aborts, then a normal read completes
    go(2'd0, 1'b0, W'(8'h55));
    step();
    done = 4'b0001;
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", W'(ready0), W'(1'b0));
    chk("arst_sel", W'(sel0), W'(2'd0));
    chk("arst_wdata", owd0, '0);
    chk("arst_valid", W'(rv0), W'(1'b0));
    #2 rst = 1'b0;
    step();
    chk("arst_no_rsp", W'(rv0), W'(1'b0));
    chk("arst_idle", W'(ready0), W'(1'b1));
    done = 4'b0;
    go(2'd0, 1'b0, W'(8'h66));
    done = 4'b0001; rdata = P2;
    step();
    step();
    chk("arst_next_valid", W'(rv0), W'(1'b1));
    chk("arst_next_rdata", ord0, P2);
    done = 4'b0;
    handshake();
    // TIMEOUT=4: done in the 4th WAIT cycle beats timeout
    bank = 2'd2; we = 1'b0; valid1 = 1'b1;
    step();
    valid1 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("coin_not_early", W'(rv1), W'(1'b0));
    done = 4'b0100; rdata = P3;
    step();
    chk("coin_valid", W'(rv1), W'(1'b1));
    chk("coin_err", W'(err1), W'(1'b0));
    chk("coin_rdata", ord1, P3);
    done = 4'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pim_bank_ctrl.md
PIM_BANK_CTRL -- requirements
Module: pim_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 256: data path width, equal to the bank dmux/mux width.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before an error response, range 1..255.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_req_valid  input  1  request valid.
REQ-006 o_req_ready  output  1  request accepted when high together with i_req_valid.
REQ-007 i_req_bank  input  2  target bank 0..3.
REQ-008 i_req_we  input  1  1 = write, 0 = read/compute.
REQ-009 i_req_wdata  input  WIDTH  write/operand data.
REQ-010 o_sel  output  2  bank select, driven to the bank dmux and mux select inputs.
REQ-011 o_wdata  output  WIDTH  registered operand, driven to the dmux data input.
REQ-012 o_bank_start  output  4  one-hot single-cycle start pulse per bank.
REQ-013 o_bank_we  output  1  write qualifier, valid while o_bank_start is nonzero.
REQ-014 i_bank_done  input  4  per-bank completion, one bit per bank, level or pulse.
REQ-015 i_bank_rdata  input  WIDTH  selected bank result, from the bank mux output.
REQ-016 o_rsp_valid  output  1  response valid.
REQ-017 i_rsp_ready  input  1  response consumed when high together with o_rsp_valid.
REQ-018 o_rsp_rdata  output  WIDTH  response data.
REQ-019 o_rsp_err  output  1  timeout flag, qualified by o_rsp_valid.

Function
REQ-020 FSM states: IDLE, START, WAIT, RESP; encoding is free.
REQ-021 IDLE: o_req_ready=1; all other states: o_req_ready=0.
REQ-022 IDLE with i_req_valid=1 at edge T: register bank into o_sel, register wdata into o_wdata, register we, then go to START.
REQ-023 START lasts exactly one cycle (T+1): o_bank_start = 1<<o_sel and o_bank_we = registered we; then go to WAIT with the wait counter at 0.
REQ-024 o_bank_start SHALL be 0 in every state except START.
REQ-025 WAIT, i_bank_done[o_sel]=1: for a read, capture i_bank_rdata into o_rsp_rdata; for a write, o_rsp_rdata=0; o_rsp_err=0; go to RESP.
REQ-026 WAIT, done not seen: increment the counter; when the counter equals TIMEOUT-1 at the edge, go to RESP with o_rsp_err=1 and o_rsp_rdata=0.
REQ-027 Done and timeout in the same cycle: done wins, err=0.
REQ-028 i_bank_done bits of non-selected banks SHALL be ignored in all states.
REQ-029 i_bank_done SHALL be ignored in IDLE, START and RESP; done is sampled only in WAIT.
REQ-030 RESP: o_rsp_valid=1; o_rsp_rdata and o_rsp_err held stable until i_rsp_ready=1, then go to IDLE and o_rsp_valid=0 on the next cycle.
REQ-031 o_sel and o_wdata held stable from accept through the response handshake, and retained in IDLE.
REQ-032 Minimum request-to-response latency: accept at T, start at T+1, done sampled at T+2 at the earliest, o_rsp_valid high from T+3.
REQ-033 Back-to-back throughput: a new request SHALL NOT be accepted in the cycle the response completes; the earliest next accept is the following cycle, in IDLE.
REQ-034 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-035 On i_rst=1, asynchronously: state=IDLE, counter=0, o_sel=0, o_wdata=0, o_bank_start=0, o_bank_we=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_req_ready=0 while reset is asserted.
REQ-036 Reset asserted mid-operation (START, WAIT or RESP) SHALL abort the transaction with no response; a pending start pulse is dropped.
REQ-037 The first accept is possible on the first rising edge after i_rst deasserts.

Verification
REQ-038 Read bank 2, done[2] one cycle after start, rdata=0xA5 repeated -> o_bank_start=4'b0100 for 1 cycle, o_sel=2, response rdata=0xA5 repeated, err=0, valid at T+3.
REQ-039 Write bank 1, wdata=0x1234 -> o_wdata=0x1234, o_bank_we=1 during start, response rdata=0, err=0.
REQ-040 Bank 3 request, done never asserted, TIMEOUT=8 -> response after 8 WAIT cycles with err=1, rdata=0; done[0..2] toggling throughout has no effect.
REQ-041 Response held with i_rsp_ready=0 for 5 cycles and a new request pending -> data stable, o_req_ready=0, second request accepted the cycle after the handshake.
REQ-042 i_rst pulsed during WAIT -> all outputs return to reset values immediately, no response issued, next request completes normally.
REQ-043 Done and timeout coincide, TIMEOUT=4, done[sel] in the 4th WAIT cycle -> err=0, rdata captured.
